alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
Controller that shares the single 4-bit ALU between two requesters.
- Each requester presents operands and an op-code over a valid/ready request channel.
- The block arbitrates round-robin, drives the ALU inputs from registered holding state, and captures result and flags.
- It returns the result to the winning requester over a valid/ready response channel.
- The ALU stays combinational and sits outside this block; FS codes are opaque here and forwarded unchanged.

Parameters:
- W, 4, operand/result width.
- FSW, 3, op-code width.
- CNT_W, 8, completed-operation counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 request valid.
- req0_ready  out  1  requester 0 request accepted this cycle when valid also high.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_fs  in  FSW  requester 0 op-code.
- resp0_valid  out  1  result valid for requester 0.
- resp0_ready  in  1  requester 0 takes result.
- resp0_y  out  W  result.
- resp0_flags  out  4  {C,V,N,Z}.
- req1_* / resp1_*  same set for requester 1.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_fs  out  FSW  to ALU FS.
- alu_y  in  W  ALU result.
- alu_c, alu_v, alu_n, alu_z  in  1 each  ALU flags.
- op_count  out  CNT_W  completed operations.
- busy  out  1  state != IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; all resp*_valid=0.
  - resp*_y=0, resp*_flags=0.
  - alu_a/alu_b/alu_fs=0; op_count=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - grant = only valid requester; if both are valid, the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. ready may depend combinationally on valid; exactly one ready at most.
  - On valid&&ready: latch a, b, fs into the alu_* registers, latch owner, go to EXEC.
  - No valid: stay in IDLE, no ready asserted.
- EXEC (exactly one cycle):
  - ALU settles from the registered inputs.
  - At the end of the cycle capture alu_y and {alu_c,alu_v,alu_n,alu_z} into the owner's resp regs; go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp_valid stays 0.
  - Hold y/flags stable until resp<owner>_ready=1.
  - On handshake: resp_valid drops next cycle, state returns to IDLE, last_grant=owner, op_count+=1 (wraps to 0 after 2^CNT_W-1).
- Latency:
  - Accept at edge T; resp_valid high from T+2.
  - With resp_ready held high, next accept is possible at T+3; minimum 3 cycles per operation.
- Back-pressure: RESP holds indefinitely; no new requests are accepted while not IDLE.
- alu_a/alu_b/alu_fs retain the last operation's values after completion; changed only on accept or reset.
- Requesters must hold a/b/fs stable while valid && !ready; the controller does not check this.
- resp*_y/flags keep their last values after the handshake; they are meaningful only while valid.
- Reset mid-operation, in any state: the in-flight operation is discarded. No response is issued, op_count is not incremented, and all outputs return to reset values on the next edge.
- A request arriving while busy waits; round-robin is evaluated on the IDLE cycle, not at arrival time.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - flag bit indices C=3, V=2, N=1, Z=0;
  - defaults for W, FSW, CNT_W.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Output: one-hot gnt.
  - Purely combinational; last_grant is held in the parent.

Test Plan:
Bench ALU stub returns y=(A+B) mod 16, C=carry, V=0, N=y[3], Z=(y==0) regardless of FS; the bench checks that alu_fs equals the request fs.
- Single op: req0 a=3, b=5, fs=3'b010, resp0_ready=1 → req0_ready at T, alu_fs=010 during EXEC, resp0_valid at T+2 with y=8, flags=0010; op_count=1.
- Tie: req0 and req1 valid at the same edge after reset → req0 granted first, then req1 granted at the next IDLE; alternation continues while both are held.
- Back-pressure: resp1_ready=0 for 5 cycles after resp1_valid with a=15, b=1 → y=0, flags=1001 held stable for 5 cycles. req0_ready stays 0 throughout; IDLE is re-entered only after the handshake.
- Reset during EXEC: accept req0, assert rst in the EXEC cycle → no resp0_valid ever; op_count=0; alu_a=0, busy=0 next cycle.
- Counter wrap: run 256 ops back-to-back with resp_ready=1 → op_count reads 0 after the 256th handshake; cycles per op are exactly 3.
- Late arrival: req1 asserted mid-op for req0, req0 re-requests immediately → req1 granted next, not req0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Shared types and constants for the shared-ALU controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

    localparam int c_w_def     = 4;
    localparam int c_fsw_def   = 3;
    localparam int c_cnt_w_def = 8;

    // Bit positions inside the 4-bit flag vector {C,V,N,Z}
    localparam int c_flag_c = 3;
    localparam int c_flag_v = 2;
    localparam int c_flag_n = 1;
    localparam int c_flag_z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational 2-way round-robin arbiter; history kept by parent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // On a tie the requester that was not served last wins
            if (&req) gnt = last_grant ? 2'b01 : 2'b10;
            else      gnt = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ============================================================================
// Module   : alu_share_ctrl
// Brief    : Shares one external combinational ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W     = c_w_def,
    parameter int FSW   = c_fsw_def,
    parameter int CNT_W = c_cnt_w_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [FSW-1:0]   req0_fs,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [W-1:0]     resp0_y,
    output logic [3:0]       resp0_flags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [FSW-1:0]   req1_fs,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [W-1:0]     resp1_y,
    output logic [3:0]       resp1_flags,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [FSW-1:0]   alu_fs,
    input  logic [W-1:0]     alu_y,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             alu_z,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_last_grant;
    logic [W-1:0]     r_alu_a;
    logic [W-1:0]     r_alu_b;
    logic [FSW-1:0]   r_alu_fs;
    logic [W-1:0]     r_y0;
    logic [W-1:0]     r_y1;
    logic [3:0]       r_f0;
    logic [3:0]       r_f1;
    logic [CNT_W-1:0] r_op_count;

    logic [1:0]       w_gnt;
    logic             w_idle;
    logic             w_accept;
    logic             w_resp_hs;
    logic [3:0]       w_flags;

    assign w_idle = (r_state == IDLE);

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .en         (w_idle),
        .gnt        (w_gnt)
    );

    // A grant is only ever issued to a valid requester, so any grant is an accept
    assign w_accept  = |w_gnt;
    assign w_resp_hs = (r_state == RESP) && (r_owner ? resp1_ready : resp0_ready);

    assign w_flags[c_flag_c] = alu_c;
    assign w_flags[c_flag_v] = alu_v;
    assign w_flags[c_flag_n] = alu_n;
    assign w_flags[c_flag_z] = alu_z;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_resp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_fs     <= '0;
            r_y0         <= '0;
            r_y1         <= '0;
            r_f0         <= '0;
            r_f1         <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_gnt[1];
                r_alu_a  <= w_gnt[1] ? req1_a  : req0_a;
                r_alu_b  <= w_gnt[1] ? req1_b  : req0_b;
                r_alu_fs <= w_gnt[1] ? req1_fs : req0_fs;
            end
            // ALU has had the whole EXEC cycle to settle from the held operands
            if (r_state == EXEC) begin
                if (r_owner) begin
                    r_y1 <= alu_y;
                    r_f1 <= w_flags;
                end else begin
                    r_y0 <= alu_y;
                    r_f0 <= w_flags;
                end
            end
            if (w_resp_hs) begin
                r_last_grant <= r_owner;
                r_op_count   <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign req0_ready  = w_gnt[0];
    assign req1_ready  = w_gnt[1];
    assign resp0_valid = (r_state == RESP) && !r_owner;
    assign resp1_valid = (r_state == RESP) &&  r_owner;
    assign resp0_y     = r_y0;
    assign resp1_y     = r_y1;
    assign resp0_flags = r_f0;
    assign resp1_flags = r_f1;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_fs      = r_alu_fs;
    assign op_count    = r_op_count;
    assign busy        = !w_idle;

endmodule

`default_nettype wire
